// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter with hold / +4 / aligned-target next-PC select and link adder.
// Single-cycle update; holds whenever adv_i is low and init_i is low.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_i,
    input  logic        adv_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc8_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (init_i) begin
            pc_d = PC_RESET;
        end else if (adv_i) begin
            // Redirect targets are forced word-aligned.
            pc_d = br_taken_i ? (br_target_i & ~32'd3) : pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o  = pc_q;
    assign pc8_o = pc_q + 32'd8;

endmodule

// File: rtl/im_fetch_ctrl.sv
// Fetch controller: boot-load the instruction RAM via valid/ready, then run the IF stage.
// Fetched instruction lands in IF/ID one cycle after a non-stalled RUN cycle; ld_ready only in LOAD.
module im_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned LOAD_WORDS = 1024,
    parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_start,
    input  logic               run_start,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [31:0]        im_addr,
    output logic               im_we,
    output logic [ADDR_W-1:0]  im_waddr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc8,
    output logic               if_valid,
    output logic               busy,
    output logic               load_err
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LOAD_WORDS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   load_cnt_q, load_cnt_d;
    logic                load_err_q, load_err_d;
    logic                pc_init;
    logic                fetch_adv;
    logic [31:0]         pc;
    logic [31:0]         pc8;

    logic [INSTR_W-1:0]  if_instr_q;
    logic [31:0]         if_pc_q, if_pc8_q;
    logic                if_valid_q;

    assign fetch_adv = (state_q == RUN) && !stall;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        load_err_d = load_err_q;
        pc_init    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    state_d    = LOAD;
                    load_cnt_d = '0;
                end else if (run_start) begin
                    state_d = RUN;
                    pc_init = 1'b1;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    load_cnt_d = load_cnt_q + ADDR_W'(1);
                    if (ld_last) begin
                        state_d = RUN;
                        pc_init = 1'b1;
                    end else if (load_cnt_q == LAST_IDX) begin
                        // Session filled without ld_last: flag it and run anyway.
                        load_err_d = 1'b1;
                        state_d    = RUN;
                        pc_init    = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            load_err_q <= load_err_d;
        end
    end

    pc_reg #(
        .PC_RESET (PC_RESET)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (reset),
        .init_i      (pc_init),
        .adv_i       (fetch_adv),
        .br_taken_i  (br_taken),
        .br_target_i (br_target),
        .pc_o        (pc),
        .pc8_o       (pc8)
    );

    // The instruction fetched alongside br_taken is the delay slot and is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_pc8_q   <= '0;
            if_valid_q <= 1'b0;
        end else if (fetch_adv) begin
            if_instr_q <= instr_in;
            if_pc_q    <= pc;
            if_pc8_q   <= pc8;
            if_valid_q <= 1'b1;
        end
    end

    assign ld_ready = (state_q == LOAD);
    assign im_we    = ld_valid && ld_ready;
    assign im_waddr = load_cnt_q;
    assign im_wdata = ld_data;
    assign im_addr  = pc;
    assign busy     = (state_q != RUN);
    assign load_err = load_err_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;
    assign if_pc8   = if_pc8_q;
    assign if_valid = if_valid_q;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl with a 4-word load limit and a pc-derived instruction pattern.
module tb_im_fetch_ctrl;

    localparam logic [31:0] PAT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_start, run_start, ld_valid, ld_last;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        stall, br_taken;
    logic [31:0] br_target;
    logic [31:0] instr_in;
    logic [31:0] im_addr;
    logic        im_we;
    logic [9:0]  im_waddr;
    logic [31:0] im_wdata;
    logic [31:0] if_instr, if_pc, if_pc8;
    logic        if_valid, busy, load_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign instr_in = im_addr ^ PAT;

    im_fetch_ctrl #(
        .ADDR_W     (10),
        .LOAD_WORDS (4),
        .PC_RESET   (32'h0000_3000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_start  (ld_start),
        .run_start (run_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .instr_in  (instr_in),
        .im_addr   (im_addr),
        .im_we     (im_we),
        .im_waddr  (im_waddr),
        .im_wdata  (im_wdata),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .if_pc8    (if_pc8),
        .if_valid  (if_valid),
        .busy      (busy),
        .load_err  (load_err)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; ld_start = 1'b0; run_start = 1'b0; ld_valid = 1'b0;
        ld_last = 1'b0; ld_data = '0; stall = 1'b0; br_taken = 1'b0; br_target = '0;

        // Reset state
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_im_we", 32'(im_we), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_im_addr", im_addr, 32'h3000);
        chk("rst_if_pc", if_pc, 32'h0);

        // Three-word load with a two-cycle ld_valid gap
        tick();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("ld_ready_in_load", 32'(ld_ready), 32'd1);
        ld_valid = 1'b1; ld_data = 32'h11;
        #1;
        chk("w0_we", 32'(im_we), 32'd1);
        chk("w0_waddr", 32'(im_waddr), 32'd0);
        chk("w0_wdata", im_wdata, 32'h11);
        tick();
        ld_valid = 1'b0;
        #1;
        chk("gap_we", 32'(im_we), 32'd0);
        chk("gap_waddr", 32'(im_waddr), 32'd1);
        tick();
        chk("gap2_waddr", 32'(im_waddr), 32'd1);
        chk("gap2_ready", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b1; ld_data = 32'h22;
        #1;
        chk("w1_waddr", 32'(im_waddr), 32'd1);
        chk("w1_we", 32'(im_we), 32'd1);
        tick();
        ld_data = 32'h33; ld_last = 1'b1;
        #1;
        chk("w2_waddr", 32'(im_waddr), 32'd2);
        chk("w2_wdata", im_wdata, 32'h33);
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        chk("run_busy", 32'(busy), 32'd0);
        chk("run_ld_ready", 32'(ld_ready), 32'd0);
        chk("run_load_err", 32'(load_err), 32'd0);
        chk("run_im_addr", im_addr, 32'h3000);
        chk("run_if_valid0", 32'(if_valid), 32'd0);

        // Sequential fetch and delayed-slot redirect
        tick();
        chk("f0_if_pc", if_pc, 32'h3000);
        chk("f0_if_instr", if_instr, 32'h3000 ^ PAT);
        chk("f0_if_pc8", if_pc8, 32'h3008);
        chk("f0_if_valid", 32'(if_valid), 32'd1);
        chk("f0_im_addr", im_addr, 32'h3004);
        tick();
        chk("f1_if_pc", if_pc, 32'h3004);
        chk("f1_if_pc8", if_pc8, 32'h300C);
        br_taken = 1'b1; br_target = 32'h3041;
        tick();
        br_taken = 1'b0;
        chk("slot_if_pc", if_pc, 32'h3008);
        chk("slot_if_instr", if_instr, 32'h3008 ^ PAT);
        chk("br_im_addr", im_addr, 32'h3040);
        tick();
        chk("tgt_if_pc", if_pc, 32'h3040);
        chk("tgt_if_pc8", if_pc8, 32'h3048);
        chk("tgt_if_instr", if_instr, 32'h3040 ^ PAT);

        // Stall holds pc and IF/ID, ignoring a concurrent redirect
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h5000;
        tick();
        chk("st0_if_pc", if_pc, 32'h3040);
        chk("st0_im_addr", im_addr, 32'h3044);
        tick();
        chk("st1_if_pc", if_pc, 32'h3040);
        chk("st1_im_addr", im_addr, 32'h3044);
        stall = 1'b0; br_taken = 1'b0;
        ld_start = 1'b1; run_start = 1'b1;
        tick();
        ld_start = 1'b0; run_start = 1'b0;
        chk("rel_if_pc", if_pc, 32'h3044);
        chk("rel_im_addr", im_addr, 32'h3048);
        chk("run_ignores_start", 32'(busy), 32'd0);

        // PC wrap-around at the top of the address space
        br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
        tick();
        br_taken = 1'b0;
        chk("wrap_pc", im_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_if_pc8", if_pc8, 32'h0000_0004);
        chk("wrap_im_addr", im_addr, 32'h0);

        // Asynchronous reset takes effect mid-cycle
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd1);
        chk("arst_if_valid", 32'(if_valid), 32'd0);
        chk("arst_im_addr", im_addr, 32'h3000);
        tick();
        reset = 1'b1;

        // Overflow: five words offered, no ld_last, limit of four
        tick();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_data = 32'hA0 + 32'(i);
            #1;
            chk("ovf_we", 32'(im_we), 32'd1);
            chk("ovf_waddr", 32'(im_waddr), 32'(i));
            tick();
        end
        ld_data = 32'hA4;
        #1;
        chk("ovf_err", 32'(load_err), 32'd1);
        chk("ovf_ready", 32'(ld_ready), 32'd0);
        chk("ovf_we5", 32'(im_we), 32'd0);
        chk("ovf_busy", 32'(busy), 32'd0);
        chk("ovf_im_addr", im_addr, 32'h3000);
        tick();
        chk("ovf_err_sticky", 32'(load_err), 32'd1);
        chk("ovf_ready2", 32'(ld_ready), 32'd0);
        ld_valid = 1'b0;

        // Simultaneous starts pick LOAD; reset mid-LOAD restarts at index 0
        reset = 1'b0;
        #1;
        chk("rst_clears_err", 32'(load_err), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        ld_start = 1'b1; run_start = 1'b1;
        tick();
        ld_start = 1'b0; run_start = 1'b0;
        chk("both_ld_ready", 32'(ld_ready), 32'd1);
        chk("both_busy", 32'(busy), 32'd1);
        ld_valid = 1'b1; ld_data = 32'h55;
        tick();
        ld_data = 32'h66;
        tick();
        chk("mid_waddr", 32'(im_waddr), 32'd2);
        ld_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ld_ready), 32'd0);
        chk("mid_rst_waddr", 32'(im_waddr), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("idle_ready", 32'(ld_ready), 32'd0);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_data = 32'h70 + 32'(i);
            ld_last = (i == 3);
            #1;
            chk("reld_waddr", 32'(im_waddr), 32'(i));
            chk("reld_wdata", im_wdata, 32'h70 + 32'(i));
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("full_last_noerr", 32'(load_err), 32'd0);
        chk("full_last_run", 32'(busy), 32'd0);

        // IDLE -> RUN without loading
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        chk("runst_busy", 32'(busy), 32'd0);
        chk("runst_if_valid", 32'(if_valid), 32'd0);
        tick();
        chk("runst_if_pc", if_pc, 32'h3000);
        chk("runst_if_valid1", 32'(if_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/im_fetch_ctrl.md
Name: im_fetch_ctrl

Overview:
Instruction-fetch controller that owns the instruction memory port and drives the IF stage of the pipelined MIPS core.
- After reset, a boot loader streams program words into the instruction RAM through a valid/ready handshake.
- The block then switches to RUN and sequences the PC: sequential fetch, one-delay-slot branch/jump redirect, and stall hold.
- It registers the fetched instruction into the IF/ID pipeline register.

Parameters:
- ADDR_W, 10, instruction RAM word-index width (RAM depth 2^ADDR_W words; word index = byte address bits [ADDR_W+1:2]).
- LOAD_WORDS, 1024, maximum words accepted per load session; must be ≤ 2^ADDR_W.
- PC_RESET, 32'h0000_3000, PC value on reset and on LOAD→RUN / IDLE→RUN entry.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ld_start  in  1  request to begin a load session (sampled in IDLE only).
- run_start  in  1  request to run without loading (sampled in IDLE only).
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader word.
- ld_last  in  1  qualifies ld_data as the final word of the session.
- ld_ready  out  1  block accepts a loader word this cycle.
- stall  in  1  hazard-unit stall request from ID.
- br_taken  in  1  redirect request from ID (branch or jump resolved).
- br_target  in  32  redirect byte address.
- instr_in  in  32  instruction RAM read data (combinational read of im_addr).
- im_addr  out  32  read byte address, equal to the current PC.
- im_we  out  1  RAM write enable.
- im_waddr  out  ADDR_W  RAM write word index.
- im_wdata  out  32  RAM write data.
- if_instr  out  32  IF/ID instruction register.
- if_pc  out  32  IF/ID PC of the captured instruction.
- if_pc8  out  32  if_pc + 8 (link address for jal/jalr).
- if_valid  out  1  IF/ID register holds a real fetched instruction.
- busy  out  1  high whenever state ≠ RUN.
- load_err  out  1  sticky flag: load session overflowed LOAD_WORDS.

Behaviour:
Reset (reset = 0, asynchronous):
- state = IDLE, pc = PC_RESET, load_cnt = 0, load_err = 0.
- if_instr = 0, if_pc = 0, if_pc8 = 0, if_valid = 0.
- Combinational outputs follow: ld_ready = 0, im_we = 0, busy = 1.

Combinational outputs:
- ld_ready = (state == LOAD).
- im_we = ld_valid & ld_ready.
- im_waddr = load_cnt; im_wdata = ld_data.
- im_addr = pc.
- busy = (state != RUN).

IDLE:
- ld_start → LOAD, with load_cnt ← 0.
- Otherwise run_start → RUN, with pc ← PC_RESET.
- ld_start and run_start together: ld_start wins.

LOAD:
- A transfer occurs on each cycle with ld_valid & ld_ready; it writes the RAM and sets load_cnt ← load_cnt + 1.
- Transfer with ld_last = 1 → RUN, with pc ← PC_RESET.
- Transfer with load_cnt == LOAD_WORDS-1 and ld_last = 0 → load_err ← 1 and state → RUN. No further words are accepted.
- Transfer with load_cnt == LOAD_WORDS-1 and ld_last = 1 → RUN, with no error.
- ld_valid = 0 → no write and no count change; the block waits indefinitely.

RUN (terminal until reset):
- ld_start and run_start are ignored.
- Per cycle, with stall = 0:
  - if_instr ← instr_in, if_pc ← pc, if_pc8 ← pc + 8, if_valid ← 1.
  - pc ← br_taken ? {br_target[31:2], 2'b00} : pc + 4.
  - Delay slot: the instruction fetched in the same cycle as br_taken is still captured and not squashed.
- stall = 1: pc and all if_* registers hold. A concurrent br_taken is ignored; ID re-asserts it once the stall releases.

Timing and arithmetic:
- Latency: the instruction at PC_RESET appears in if_instr 1 cycle after entering RUN.
- pc arithmetic is mod 2^32: 32'hFFFF_FFFC + 4 = 0.
- if_valid stays 0 until the first non-stalled RUN cycle.

Reset mid-operation:
- Reset during LOAD returns to IDLE. Partial RAM contents are not cleared.
- load_err is cleared only by reset.

Decomposition:
- Shared package `fetch_pkg`: state enum {IDLE, LOAD, RUN} (2-bit), PC_RESET default, and the INSTR_W = 32 constant.
- One natural sub-module, `pc_reg`: holds the PC register, the next-PC mux (hold / +4 / target) with target alignment, and the +8 adder.
- The FSM and IF/ID register stay in im_fetch_ctrl.

Test Plan:
1. Reset held low 3 cycles, then release → busy = 1, ld_ready = 0, im_we = 0, if_valid = 0, im_addr = 32'h3000. Assert reset asynchronously mid-cycle → outputs change immediately.
2. ld_start, then words 0x11, 0x22, 0x33 with ld_valid held 1 and ld_last on 0x33 → im_we high 3 cycles with im_waddr 0, 1, 2. State becomes RUN on the next edge, load_err = 0. Then ld_valid dropped for 2 cycles mid-stream → no writes, count holds.
3. Load with LOAD_WORDS = 4 and 5 words offered, ld_last never set → 4 writes (indices 0–3), load_err = 1, RUN entered, 5th word never accepted (ld_ready = 0).
4. RUN with instr_in = pc-derived pattern, no stall → if_pc sequence 0x3000, 0x3004, 0x3008 and if_pc8 = if_pc + 8. br_taken with br_target = 0x3041 at pc = 0x3008 → if_pc 0x3008 (delay slot) then 0x3040.
5. stall high 2 cycles with br_taken = 1 asserted in both cycles → pc and if_* unchanged. Release stall with br_taken = 0 → sequential fetch resumes from the held pc.
6. IDLE with ld_start = run_start = 1 → LOAD entered. Separate run: reset asserted mid-LOAD after 2 words → IDLE, load_cnt = 0; a new ld_start writes again from index 0.
